apb_arbiter: RTL and testbench

//  Two-requester APB master: shares one APB peripheral bus (uart and siblings) between
//  two requesters (e.g. core data port and debug/DMA port). Round-robin grant, drives
//  APB SETUP/ACCESS phases, waits on pready, returns read data/error per requester.

---
 rtl/apb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_apb_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, per-requester completion.
// Stalled ACCESS phases are aborted with an error after TIMEOUT_CYCLES cycles without pready.
module apb_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  m0_valid,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_write,
   input  logic [3:0]            m0_strb,
   output logic                  m0_done,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_err,
   input  logic                  m1_valid,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_write,
   input  logic [3:0]            m1_strb,
   output logic                  m1_done,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pdata,
   output logic                  pwrite,
   output logic [3:0]            pstb,
   output logic                  psel,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  perr
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic                  r_last, w_last_nxt;
   logic                  r_win, w_win_nxt;
   logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
   logic [DATA_WIDTH-1:0] r_pdata, w_pdata_nxt;
   logic                  r_pwrite, w_pwrite_nxt;
   logic [3:0]            r_pstb, w_pstb_nxt;
   logic                  r_psel, w_psel_nxt;
   logic                  r_penable, w_penable_nxt;
   logic                  r_m0_done, r_m1_done, r_m0_err, r_m1_err;
   logic [DATA_WIDTH-1:0] r_m0_rdata, r_m1_rdata;
   logic                  w_gnt1;
   logic                  w_fin, w_fin_err;
   logic [DATA_WIDTH-1:0] w_fin_rdata;

   // On a tie the requester that did not win last time is served.
   assign w_gnt1 = m1_valid & (~m0_valid | ~r_last);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_last_nxt    = r_last;
      w_win_nxt     = r_win;
      w_paddr_nxt   = r_paddr;
      w_pdata_nxt   = r_pdata;
      w_pwrite_nxt  = r_pwrite;
      w_pstb_nxt    = r_pstb;
      w_psel_nxt    = r_psel;
      w_penable_nxt = r_penable;
      w_fin         = 1'b0;
      w_fin_err     = 1'b0;
      w_fin_rdata   = '0;
      case (r_state)
         S_IDLE: begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            if (m0_valid | m1_valid) begin
               w_win_nxt    = w_gnt1;
               w_last_nxt   = w_gnt1;
               w_paddr_nxt  = w_gnt1 ? m1_addr  : m0_addr;
               w_pdata_nxt  = w_gnt1 ? m1_wdata : m0_wdata;
               w_pwrite_nxt = w_gnt1 ? m1_write : m0_write;
               w_pstb_nxt   = w_gnt1 ? m1_strb  : m0_strb;
               w_psel_nxt   = 1'b1;
               w_state_nxt  = S_SETUP;
            end
         end
         S_SETUP: begin
            w_penable_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_ACCESS;
         end
         S_ACCESS: begin
            if (pready) begin
               w_fin       = 1'b1;
               w_fin_err   = perr;
               w_fin_rdata = r_pwrite ? '0 : prdata;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_fin     = 1'b1;
               w_fin_err = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
            if (w_fin) begin
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
               w_state_nxt   = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_last     <= 1'b1;
         r_win      <= 1'b0;
         r_paddr    <= '0;
         r_pdata    <= '0;
         r_pwrite   <= 1'b0;
         r_pstb     <= '0;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_m0_done  <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_done  <= 1'b0;
         r_m1_err   <= 1'b0;
         r_m1_rdata <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_last     <= w_last_nxt;
         r_win      <= w_win_nxt;
         r_paddr    <= w_paddr_nxt;
         r_pdata    <= w_pdata_nxt;
         r_pwrite   <= w_pwrite_nxt;
         r_pstb     <= w_pstb_nxt;
         r_psel     <= w_psel_nxt;
         r_penable  <= w_penable_nxt;
         // Completion outputs live for the single DONE cycle only.
         r_m0_done  <= w_fin & ~r_win;
         r_m0_err   <= w_fin & ~r_win & w_fin_err;
         r_m0_rdata <= (w_fin & ~r_win) ? w_fin_rdata : '0;
         r_m1_done  <= w_fin & r_win;
         r_m1_err   <= w_fin & r_win & w_fin_err;
         r_m1_rdata <= (w_fin & r_win) ? w_fin_rdata : '0;
      end
   end

   assign paddr    = r_paddr;
   assign pdata    = r_pdata;
   assign pwrite   = r_pwrite;
   assign pstb     = r_pstb;
   assign psel     = r_psel;
   assign penable  = r_penable;
   assign m0_done  = r_m0_done;
   assign m0_rdata = r_m0_rdata;
   assign m0_err   = r_m0_err;
   assign m1_done  = r_m1_done;
   assign m1_rdata = r_m1_rdata;
   assign m1_err   = r_m1_err;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_apb_arbiter;
   localparam int TO = 16;

   logic        pclk = 1'b0;
   logic        presetn = 1'b1;
   logic        m0_valid = 0, m0_write = 0, m1_valid = 0, m1_write = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic [3:0]  m0_strb = 0, m1_strb = 0;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] paddr, pdata, prdata = 0;
   logic        pwrite, psel, penable;
   logic [3:0]  pstb;
   logic        pready = 0, perr = 0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .presetn(presetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
      .m0_strb(m0_strb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
      .m1_strb(m1_strb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb), .psel(psel),
      .penable(penable), .prdata(prdata), .pready(pready), .perr(perr));

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   // Slave: 0 = uart (ready on 2nd access cycle), 1 = never ready, 2 = ready always.
   // perr_mode: 0 none, 1 with ready, 2 only while not ready.
   int          slave_mode = 0, perr_mode = 0, acc = 0;
   logic [31:0] slave_rdata = 0;
   always @(negedge pclk) begin
      if (psel && penable) acc++; else acc = 0;
      case (slave_mode)
         0:       pready = (acc >= 2);
         1:       pready = 1'b0;
         default: pready = 1'b1;
      endcase
      case (perr_mode)
         1:       perr = pready;
         2:       perr = !pready && acc > 0;
         default: perr = 1'b0;
      endcase
      prdata = slave_rdata;
   end

   // Monitor of bus activity used by the directed checks.
   int          psel_rise = -1, pen_rise = -1;
   logic        prev_psel = 0, prev_pen = 0;
   logic [31:0] acc_addr = 0, acc_data = 0;
   logic        acc_write = 0;
   logic [3:0]  acc_strb = 0;
   always @(negedge pclk) begin
      if (psel && !prev_psel) psel_rise = cyc;
      if (penable && !prev_pen) pen_rise = cyc;
      if (psel && penable) begin
         acc_addr = paddr; acc_data = pdata; acc_write = pwrite; acc_strb = pstb;
      end
      prev_psel = psel;
      prev_pen = penable;
   end

   // Reference model: transaction timeline measured in cycles since grant.
   logic [31:0] e_paddr, e_pdata, e_m0_rdata, e_m1_rdata;
   logic        e_pwrite, e_psel, e_penable, e_m0_done, e_m0_err, e_m1_done, e_m1_err;
   logic [3:0]  e_pstb;
   int          m_ph;
   bit          m_in_done, m_last, m_win;

   task automatic model_finish(input logic [31:0] rd, input logic er);
      e_psel = 0; e_penable = 0;
      if (m_win) begin e_m1_done = 1; e_m1_rdata = rd; e_m1_err = er; end
      else       begin e_m0_done = 1; e_m0_rdata = rd; e_m0_err = er; end
      m_ph = -1; m_in_done = 1;
   endtask

   always @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         {e_paddr, e_pdata, e_pwrite, e_pstb, e_psel, e_penable} = '0;
         {e_m0_done, e_m0_rdata, e_m0_err, e_m1_done, e_m1_rdata, e_m1_err} = '0;
         m_ph = -1; m_in_done = 0; m_last = 1; m_win = 0;
      end else begin
         {e_m0_done, e_m0_rdata, e_m0_err, e_m1_done, e_m1_rdata, e_m1_err} = '0;
         if (m_in_done) begin
            m_in_done = 0;
         end else if (m_ph < 0) begin
            if (m0_valid || m1_valid) begin
               m_win = (m0_valid && m1_valid) ? !m_last : m1_valid;
               m_last = m_win;
               e_paddr  = m_win ? m1_addr  : m0_addr;
               e_pdata  = m_win ? m1_wdata : m0_wdata;
               e_pwrite = m_win ? m1_write : m0_write;
               e_pstb   = m_win ? m1_strb  : m0_strb;
               e_psel = 1; e_penable = 0; m_ph = 0;
            end
         end else if (m_ph == 0) begin
            e_penable = 1; m_ph = 1;
         end else if (pready) begin
            model_finish(e_pwrite ? 32'h0 : prdata, perr);
         end else if (m_ph == TO) begin
            model_finish(32'h0, 1'b1);
         end else begin
            m_ph++;
         end
      end
   end

   always @(negedge pclk) begin
      if (presetn) begin
         logic [138:0] a, e;
         a = {psel, penable, paddr, pdata, pwrite, pstb, m0_done, m0_rdata, m0_err, m1_done, m1_rdata, m1_err};
         e = {e_psel, e_penable, e_paddr, e_pdata, e_pwrite, e_pstb,
              e_m0_done, e_m0_rdata, e_m0_err, e_m1_done, e_m1_rdata, e_m1_err};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL cycle_cmp cyc=%0d actual=%h required=%h", cyc, a, e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] s);
      if (who) begin m1_addr = a; m1_wdata = d; m1_write = w; m1_strb = s; m1_valid = 1; end
      else     begin m0_addr = a; m0_wdata = d; m0_write = w; m0_strb = s; m0_valid = 1; end
   endtask

   task automatic wait_done(input bit who, input int bound, output int dcyc,
                            output logic [31:0] rd, output logic er, output bit other);
      bit got = 0;
      dcyc = -1; rd = 0; er = 0; other = 0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge pclk);
         if (who ? m1_done : m0_done) begin
            got = 1; dcyc = cyc;
            rd = who ? m1_rdata : m0_rdata;
            er = who ? m1_err : m0_err;
         end
         if (who ? m0_done : m1_done) other = 1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL wait_done m%0d actual=no_done required=done within %0d cycles", who, bound);
      end
      if (who) m1_valid = 0; else m0_valid = 0;
   endtask

   initial begin
      int n, d, ord, cnt, first;
      logic [31:0] rd;
      logic er;
      bit oth;
      #1 presetn = 0;
      repeat (2) @(negedge pclk);
      chk("reset_psel", {31'b0, psel}, 0);
      chk("reset_penable", {31'b0, penable}, 0);
      chk("reset_done", {30'b0, m0_done, m1_done}, 0);
      chk("reset_paddr", paddr, 0);
      presetn = 1;

      // m0 write through a uart-style slave
      @(negedge pclk); n = cyc;
      issue(0, 32'h1000_0000, 32'h41, 1, 4'b0001);
      wait_done(0, 20, d, rd, er, oth);
      chk("t1_psel_rise", psel_rise - n, 1);
      chk("t1_pen_rise", pen_rise - n, 2);
      chk("t1_latency", d - n, 4);
      chk("t1_err", {31'b0, er}, 0);
      chk("t1_rdata", rd, 0);
      chk("t1_pdata", acc_data, 32'h41);
      chk("t1_paddr", acc_addr, 32'h1000_0000);
      chk("t1_pstb", {28'b0, acc_strb}, 1);
      chk("t1_pwrite", {31'b0, acc_write}, 1);

      // m1 read
      slave_rdata = 32'hDEAD_BEEF;
      @(negedge pclk); n = cyc;
      issue(1, 32'h1000_0004, 32'h0, 0, 4'hF);
      wait_done(1, 20, d, rd, er, oth);
      chk("t2_rdata", rd, 32'hDEAD_BEEF);
      chk("t2_err", {31'b0, er}, 0);
      chk("t2_latency", d - n, 4);
      chk("t2_m0_quiet", {31'b0, oth}, 0);

      // both held: m0,m1,m0,m1
      @(negedge pclk);
      issue(0, 32'h100, 32'h1, 1, 4'hF);
      issue(1, 32'h200, 32'h2, 1, 4'hF);
      ord = 0; cnt = 0;
      for (int i = 0; i < 80 && cnt < 4; i++) begin
         @(negedge pclk);
         if (m0_done) begin ord = ord * 2; cnt++; end
         if (m1_done) begin ord = ord * 2 + 1; cnt++; end
      end
      m0_valid = 0; m1_valid = 0;
      chk("t3_count", cnt, 4);
      chk("t3_order", ord, 32'b0101);

      // timeout, then normal recovery
      slave_mode = 1; slave_rdata = 32'h1234_5678;
      @(negedge pclk); n = cyc;
      issue(0, 32'h300, 32'h0, 0, 4'hF);
      wait_done(0, 40, d, rd, er, oth);
      chk("t4_latency", d - n, 18);
      chk("t4_err", {31'b0, er}, 1);
      chk("t4_rdata", rd, 0);
      slave_mode = 0;
      @(negedge pclk); n = cyc;
      issue(0, 32'h304, 32'h55, 1, 4'hF);
      wait_done(0, 20, d, rd, er, oth);
      chk("t4b_latency", d - n, 4);
      chk("t4b_err", {31'b0, er}, 0);

      // perr with pready on a read
      perr_mode = 1; slave_rdata = 32'hCAFE_0001;
      @(negedge pclk);
      issue(1, 32'h400, 32'h0, 0, 4'hF);
      wait_done(1, 20, d, rd, er, oth);
      chk("t5_err", {31'b0, er}, 1);
      chk("t5_rdata", rd, 32'hCAFE_0001);

      // perr without pready is ignored
      perr_mode = 2;
      @(negedge pclk);
      issue(1, 32'h404, 32'h0, 0, 4'hF);
      wait_done(1, 20, d, rd, er, oth);
      chk("t6_err", {31'b0, er}, 0);
      perr_mode = 0;

      // pready held high everywhere: only the ACCESS sample counts
      slave_mode = 2; slave_rdata = 32'hA5A5_5A5A;
      @(negedge pclk); n = cyc;
      issue(0, 32'h500, 32'h0, 0, 4'hF);
      wait_done(0, 20, d, rd, er, oth);
      chk("t7_latency", d - n, 3);
      chk("t7_rdata", rd, 32'hA5A5_5A5A);
      slave_mode = 0;

      // valid dropped right after grant still completes
      @(negedge pclk);
      issue(1, 32'h600, 32'h77, 1, 4'h3);
      @(negedge pclk); m1_valid = 0;
      wait_done(1, 20, d, rd, er, oth);
      chk("t8_err", {31'b0, er}, 0);

      // reset during ACCESS after an m0 grant; next tie must go to m0
      slave_mode = 1;
      @(negedge pclk);
      issue(0, 32'h700, 32'h0, 0, 4'hF);
      repeat (5) @(negedge pclk);
      chk("t9_pre_psel", {31'b0, psel & penable}, 1);
      #2 presetn = 0;
      #1;
      chk("t9_rst_bus", {30'b0, psel, penable}, 0);
      chk("t9_rst_done", {30'b0, m0_done, m1_done}, 0);
      @(negedge pclk);
      slave_mode = 0;
      issue(1, 32'h800, 32'h0, 1, 4'hF);
      presetn = 1;
      first = -1;
      for (int i = 0; i < 20 && first < 0; i++) begin
         @(negedge pclk);
         if (m0_done) first = 0; else if (m1_done) first = 1;
      end
      m0_valid = 0;
      chk("t9_first_after_reset", first, 0);
      wait_done(1, 20, d, rd, er, oth);

      repeat (3) @(negedge pclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
